// File: rtl/snoop_mgmt_bus_range_router_pkg.sv
// snoop_bus_pkg: register addresses and field types shared by the
// bus-number snoop / range router. Optional macro: SNOOP_SBR_CLEAR_EN.
package snoop_bus_pkg;

    localparam logic [9:0] PRI_BUS_NUM_REG_ADDR = 10'h6;
    localparam logic [9:0] BRIDGE_CTRL_REG_ADDR = 10'hF;
    localparam int         SBR_BIT              = 22;

    typedef struct packed {
        logic [7:0] pri;
        logic [7:0] sec;
        logic [7:0] sub;
    } bus_range_t;

    typedef struct packed {
        logic pri;
        logic sec;
        logic sub;
    } bus_rdy_t;

endpackage

// File: rtl/snoop_mgmt_bus_range_router_if.sv
// Config-management snoop bus plus the bus-number lookup request/response.
// master = requester (config master / TLP router), slave = the router block.
interface snoop_mgmt_bus_range_router_if #(
    parameter int IDX_W = 1
);
    logic             cfg_mgmt_write;
    logic             cfg_mgmt_read_write_done;
    logic [9:0]       cfg_mgmt_addr;
    logic [15:0]      cfg_mgmt_function_number;
    logic [31:0]      cfg_mgmt_write_data;
    logic [3:0]       cfg_mgmt_byte_enable;

    logic             lookup_valid;
    logic [7:0]       lookup_bus;
    logic             lookup_resp_valid;
    logic             lookup_hit;
    logic [IDX_W-1:0] lookup_port;
    logic             lookup_multi_hit;

    modport master (
        output cfg_mgmt_write, cfg_mgmt_read_write_done, cfg_mgmt_addr,
               cfg_mgmt_function_number, cfg_mgmt_write_data, cfg_mgmt_byte_enable,
               lookup_valid, lookup_bus,
        input  lookup_resp_valid, lookup_hit, lookup_port, lookup_multi_hit
    );

    modport slave (
        input  cfg_mgmt_write, cfg_mgmt_read_write_done, cfg_mgmt_addr,
               cfg_mgmt_function_number, cfg_mgmt_write_data, cfg_mgmt_byte_enable,
               lookup_valid, lookup_bus,
        output lookup_resp_valid, lookup_hit, lookup_port, lookup_multi_hit
    );
endinterface

// File: rtl/snoop_mgmt_bus_range_router_lookup.sv
// bus_range_lookup: combinational range match across all ports,
// lowest-index winner and a more-than-one-match flag. Parent registers it.
module bus_range_lookup #(
    parameter int N_PORTS = 2,
    parameter int IDX_W   = 1
) (
    input  logic [N_PORTS-1:0][7:0] i_sec,
    input  logic [N_PORTS-1:0][7:0] i_sub,
    input  logic [N_PORTS-1:0]      i_vld,
    input  logic [7:0]              i_bus,
    output logic                    o_hit,
    output logic [IDX_W-1:0]        o_port,
    output logic                    o_multi
);
    logic [N_PORTS-1:0] w_match;
    logic [3:0]         w_cnt;

    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_cmp
        assign w_match[gi] = i_vld[gi] & (i_bus >= i_sec[gi]) & (i_bus <= i_sub[gi]);
    end

    // Priority encode: scan downward so the lowest matching index is the last assignment
    always_comb begin
        o_port = '0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            if (w_match[i]) o_port = IDX_W'(i);
        end
    end

    // Population count of matches, only "more than one" is used
    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            w_cnt = w_cnt + 4'(w_match[i]);
        end
    end

    assign o_hit   = |w_match;
    assign o_multi = (w_cnt > 4'd1);

endmodule

// File: rtl/snoop_mgmt_bus_range_router.sv
// snoop_mgmt_bus_range_router: snoops Type-1 bus-number writes for N_PORTS
// downstream functions, keeps per-port ranges and serves a registered
// bus -> port lookup. Optional macro: SNOOP_SBR_CLEAR_EN (Secondary Bus
// Reset in Bridge Control drops that port's sec/sub ready flags).
module snoop_mgmt_bus_range_router
    import snoop_bus_pkg::*;
#(
    parameter int N_PORTS     = 2,
    parameter int IDX_W       = (N_PORTS > 1) ? $clog2(N_PORTS) : 1,
    parameter bit REQUIRE_PRI = 1'b0
) (
    input  logic                     dsp_user_clk,
    input  logic                     sys_reset_n,
    snoop_mgmt_bus_range_router_if.slave bus,
    input  logic                     usp_bus_num_rdy,
    input  logic [N_PORTS-1:0]       port_clear,
    output logic [8*N_PORTS-1:0]     pri_bus,
    output logic [8*N_PORTS-1:0]     sec_bus,
    output logic [8*N_PORTS-1:0]     sub_bus,
    output logic [N_PORTS-1:0]       port_rdy,
    output logic [N_PORTS-1:0]       range_err,
    output logic [N_PORTS-1:0]       bus_update,
    output logic                     all_bus_numbers_ready
);
    logic                     w_fn_ok;
    logic                     w_wr;
    logic                     w_cap;
    logic                     w_sbr;
    logic [IDX_W-1:0]         w_fn_idx;
    logic [31:0]              w_d;
    logic [3:0]               w_be;
    logic [N_PORTS-1:0][7:0]  w_sec_v;
    logic [N_PORTS-1:0][7:0]  w_sub_v;
    logic                     w_hit;
    logic [IDX_W-1:0]         w_port;
    logic                     w_multi;
    logic                     w_unused;

    logic                     r_vld;
    logic                     r_hit;
    logic [IDX_W-1:0]         r_port;
    logic                     r_multi;

    assign w_d      = bus.cfg_mgmt_write_data;
    assign w_be     = bus.cfg_mgmt_byte_enable;
    // Full 16-bit compare also rejects aliases with high function-number bits set
    assign w_fn_ok  = (bus.cfg_mgmt_function_number < 16'(N_PORTS));
    assign w_fn_idx = bus.cfg_mgmt_function_number[IDX_W-1:0];
    assign w_wr     = bus.cfg_mgmt_write & bus.cfg_mgmt_read_write_done & w_fn_ok;
    assign w_cap    = w_wr & (bus.cfg_mgmt_addr == PRI_BUS_NUM_REG_ADDR);
`ifdef SNOOP_SBR_CLEAR_EN
    assign w_sbr    = w_wr & (bus.cfg_mgmt_addr == BRIDGE_CTRL_REG_ADDR) & w_be[2] & w_d[SBR_BIT];
`else
    assign w_sbr    = 1'b0;
`endif
    // Latency timer byte and be[3] are never captured
    assign w_unused = ^{w_d[31:24], w_be[3], w_sbr};

    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
        bus_range_t r_rng;
        bus_rdy_t   r_rdy;
        logic       r_upd;
        logic       w_sel;
        logic       w_chg;
        logic       w_err;

        assign w_sel = w_cap & (w_fn_idx == IDX_W'(gi));
        // A pulse is due when any enabled byte differs or lands in an empty field
        assign w_chg = (w_be[0] & ((w_d[7:0]   != r_rng.pri) | ~r_rdy.pri))
                     | (w_be[1] & ((w_d[15:8]  != r_rng.sec) | ~r_rdy.sec))
                     | (w_be[2] & ((w_d[23:16] != r_rng.sub) | ~r_rdy.sub));

        // Field/flag capture; port_clear beats a same-cycle write to this port
        always_ff @(posedge dsp_user_clk or negedge sys_reset_n) begin
            if (!sys_reset_n) begin
                r_rng <= '0;
                r_rdy <= '0;
                r_upd <= 1'b0;
            end else begin
                r_upd <= 1'b0;
                if (port_clear[gi]) begin
                    r_rng <= '0;
                    r_rdy <= '0;
                end else if (w_sel) begin
                    if (w_be[0]) begin r_rng.pri <= w_d[7:0];   r_rdy.pri <= 1'b1; end
                    if (w_be[1]) begin r_rng.sec <= w_d[15:8];  r_rdy.sec <= 1'b1; end
                    if (w_be[2]) begin r_rng.sub <= w_d[23:16]; r_rdy.sub <= 1'b1; end
                    r_upd <= w_chg;
                end else if (w_sbr && (w_fn_idx == IDX_W'(gi))) begin
                    r_rdy.sec <= 1'b0;
                    r_rdy.sub <= 1'b0;
                end
            end
        end

        assign w_err           = r_rdy.sec & r_rdy.sub &
                                 ((r_rng.sec == 8'd0) | (r_rng.sec > r_rng.sub));
        assign range_err[gi]   = w_err;
        assign port_rdy[gi]    = r_rdy.sec & r_rdy.sub & ~w_err & (r_rdy.pri | ~REQUIRE_PRI);
        assign bus_update[gi]  = r_upd;
        assign pri_bus[8*gi +: 8] = r_rng.pri;
        assign sec_bus[8*gi +: 8] = r_rng.sec;
        assign sub_bus[8*gi +: 8] = r_rng.sub;
        assign w_sec_v[gi]     = r_rng.sec;
        assign w_sub_v[gi]     = r_rng.sub;
    end

    assign all_bus_numbers_ready = usp_bus_num_rdy & (&port_rdy);

    bus_range_lookup #(
        .N_PORTS (N_PORTS),
        .IDX_W   (IDX_W)
    ) u_lookup (
        .i_sec   (w_sec_v),
        .i_sub   (w_sub_v),
        .i_vld   (port_rdy),
        .i_bus   (bus.lookup_bus),
        .o_hit   (w_hit),
        .o_port  (w_port),
        .o_multi (w_multi)
    );

    // One-stage lookup response; result fields are forced to 0 when not valid
    always_ff @(posedge dsp_user_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_vld   <= 1'b0;
            r_hit   <= 1'b0;
            r_port  <= '0;
            r_multi <= 1'b0;
        end else begin
            r_vld   <= bus.lookup_valid;
            r_hit   <= bus.lookup_valid & w_hit;
            r_port  <= (bus.lookup_valid & w_hit) ? w_port : '0;
            r_multi <= bus.lookup_valid & w_multi;
        end
    end

    assign bus.lookup_resp_valid = r_vld;
    assign bus.lookup_hit        = r_hit;
    assign bus.lookup_port       = r_port;
    assign bus.lookup_multi_hit  = r_multi;

endmodule

// File: doc/snoop_mgmt_bus_range_router.md
Name: snoop_mgmt_bus_range_router

Overview:
- Parametrised successor to the single-DSP bus-number snoop.
- Snoops configuration-management writes to the Type-1 header of N_PORTS downstream functions.
- Keeps per-port primary/secondary/subordinate bus numbers and per-field ready flags.
- Provides a registered bus-number→port lookup that the switch TLP router uses for ID-routed and configuration traffic.

Parameters:
- N_PORTS, 2, number of downstream functions snooped; function index 0..N_PORTS-1; legal range 1..8.
- IDX_W, $clog2(N_PORTS) (min 1), width of the port index.
- REQUIRE_PRI, 0, if 1 the primary bus ready flag is also required for port_rdy.

Ports:
- dsp_user_clk  in  1  single clock.
- sys_reset_n  in  1  asynchronous active-low reset.
- cfg_mgmt_write  in  1  write strobe.
- cfg_mgmt_read_write_done  in  1  access completion.
- cfg_mgmt_addr  in  10  DWORD address.
- cfg_mgmt_function_number  in  16  target function.
- cfg_mgmt_write_data  in  32  write data.
- cfg_mgmt_byte_enable  in  4  byte enables.
- usp_bus_num_rdy  in  1  upstream bus numbers valid, already synchronised to this domain.
- port_clear  in  N_PORTS  per-port clear (link-down or hot reset).
- lookup_valid  in  1  lookup request.
- lookup_bus  in  8  bus number to route.
- pri_bus  out  8*N_PORTS  packed; port i occupies [8i+7:8i].
- sec_bus  out  8*N_PORTS  packed, same layout.
- sub_bus  out  8*N_PORTS  packed, same layout.
- port_rdy  out  N_PORTS  port range programmed and valid.
- range_err  out  N_PORTS  sec==0 or sec>sub while both fields are ready.
- bus_update  out  N_PORTS  1-cycle pulse when any field of the port changes value.
- all_bus_numbers_ready  out  1  usp_bus_num_rdy AND all port_rdy.
- lookup_resp_valid  out  1  lookup result valid.
- lookup_hit  out  1  lookup_bus lies inside a ready port's range.
- lookup_port  out  IDX_W  matching port index.
- lookup_multi_hit  out  1  more than one ready port matched.

Behaviour:
- Capture qualifier, all in one cycle:
  - cfg_mgmt_write and cfg_mgmt_read_write_done are both 1;
  - cfg_mgmt_addr == 10'h6;
  - cfg_mgmt_function_number < N_PORTS, with bits [15:IDX_W] zero.
  - Any other function number or address is ignored.
- Field capture under the qualifier:
  - be[0] → pri = data[7:0], pri_rdy = 1.
  - be[1] → sec = data[15:8], sec_rdy = 1.
  - be[2] → sub = data[23:16], sub_rdy = 1.
  - be[3] is ignored (secondary latency timer).
- Capture latency: registers and flags update on the clock edge after the qualifying cycle; outputs are visible in the next cycle.
- bus_update[i] pulses in that same cycle only if a captured byte differs from its old value or its ready flag was 0.
- port_rdy[i] = sec_rdy & sub_rdy & ~range_err[i], ANDed with pri_rdy when REQUIRE_PRI=1. Registered; it follows the field registers combinationally and has no extra latency.
- range_err[i] is combinational from the registers and is only asserted when sec_rdy and sub_rdy are both set.
- Rewrites are allowed at any time, overwrite in place, and do not drop ready flags.
- port_clear[i]:
  - clears all three fields of port i to 0 and all its flags to 0 on the next edge;
  - wins over a simultaneous write to the same port;
  - a write to another port in the same cycle proceeds.
- Lookup pipeline (1-cycle latency, no backpressure, one request per cycle):
  - lookup_resp_valid = registered lookup_valid.
  - Match set: ports with port_rdy=1 and sec ≤ lookup_bus ≤ sub, using unsigned 8-bit compares and the register values from the request cycle (pre-write).
  - lookup_hit = match set non-empty; lookup_port = lowest matching index; lookup_multi_hit = popcount > 1.
  - On miss, lookup_port = 0.
  - When lookup_resp_valid=0, lookup_hit, lookup_port and lookup_multi_hit are held at 0.
- Boundaries:
  - lookup_bus == sec and lookup_bus == sub both hit.
  - lookup_bus == 8'hFF hits only if sub == 8'hFF.
  - lookup_bus == 0 never hits a valid range.
- Reset (sys_reset_n low, asynchronous, including mid-lookup or mid-write): all field registers = 0, all flags = 0. Every output is 0, including pipeline registers. The first capture is possible on the first edge after deassertion.

Optional Feature:
- Macro: SNOOP_SBR_CLEAR_EN.
- Defined:
  - A qualified write with cfg_mgmt_addr == 10'hF, be[2]=1 and data[22]=1 (Bridge Control Secondary Bus Reset) clears sec_rdy and sub_rdy of that port on the next edge, with register values kept.
  - A write with data[22]=0 has no effect.
  - port_clear still has priority.
- Undefined: address 10'hF is ignored completely.

Decomposition:
- Package snoop_bus_pkg:
  - localparams PRI_BUS_NUM_REG_ADDR = 10'h6, BRIDGE_CTRL_REG_ADDR = 10'hF, SBR_BIT = 22;
  - typedef struct packed {logic [7:0] pri, sec, sub;} bus_range_t;
  - typedef struct packed {logic pri, sec, sub;} bus_rdy_t.
- Sub-module bus_range_lookup: N_PORTS range comparators, lowest-index priority encoder and popcount>1. It is combinational and is registered by the parent.

Test Plan:
- fn 0, addr 6, be 4'b0111, data 32'h00050201 → next cycle pri[0]=01, sec[0]=02, sub[0]=05, port_rdy[0]=1, bus_update[0] pulses for 1 cycle; all_bus_numbers_ready=1 only after usp_bus_num_rdy and port 1 are also ready.
- fn 1, be 4'b0010, data 32'h00000600 → sec[1]=06, port_rdy[1]=0. Then be 4'b0100, data 32'h00090000 → sub[1]=09, port_rdy[1]=1. Rewriting the same values gives no bus_update pulse.
- With N_PORTS=2: fn 2 and fn 16'h0100 writes are ignored; write_done=0 with write=1 is ignored; addr 7 is ignored.
- Ranges p0 2..5 and p1 6..9:
  - lookup 7 → hit=1, port=1, next cycle;
  - lookup 10 → hit=0;
  - reprogram p1 to 4..9, then lookup 4 → port=0, multi_hit=1;
  - p1 written to sec=9, sub=6 → range_err[1]=1, port_rdy[1]=0.
- port_clear[1] in the same cycle as a write to p1 → p1 fields all 0 and port_rdy[1]=0; a simultaneous write to p0 still captures.
- SNOOP_SBR_CLEAR_EN defined: fn 0, addr F, be 4'b0100, data bit 22 = 1 → port_rdy[0] goes 0 and sec[0]/sub[0] are unchanged. Undefined: no change.
